// File: rtl/can_apb_arb_pkg.sv
// rtl/can_apb_arb_pkg.sv - shared types and constants for the CAN APB arbiter
package can_apb_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_SETUP  = 2'd1,
        ARB_ACCESS = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    localparam int APB_ADDR_W = 32;
    localparam int APB_DATA_W = 32;
    localparam int APB_STRB_W = APB_DATA_W / 8;

    localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/can_rr_arbiter.sv
// rtl/can_rr_arbiter.sv - combinational round-robin grant, search starts after last_grant
module can_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        found     = 1'b0;
        // last_grant itself is checked last, so a persistent requester yields to all others
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                grant_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/can_apb_arbiter.sv
// rtl/can_apb_arbiter.sv - N-requester round-robin front end onto one APB4 master port
module can_apb_arbiter
    import can_apb_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 64
) (
    input  logic                         aclk,
    input  logic                         arst,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    input  logic [NUM_REQ-1:0]           req_write_i,
    input  logic [NUM_REQ*APB_ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*APB_DATA_W-1:0] req_wdata_i,
    input  logic [NUM_REQ*APB_STRB_W-1:0] req_strb_i,
    output logic [NUM_REQ-1:0]           rsp_valid_o,
    output logic [APB_DATA_W-1:0]        rsp_rdata_o,
    output logic                         rsp_err_o,
    output logic                         m_apb_psel_o,
    output logic                         m_apb_penable_o,
    output logic                         m_apb_pwrite_o,
    output logic [APB_ADDR_W-1:0]        m_apb_paddr_o,
    output logic [APB_DATA_W-1:0]        m_apb_pwdata_o,
    output logic [APB_STRB_W-1:0]        m_apb_pstrb_o,
    output logic [2:0]                   m_apb_pprot_o,
    input  logic [APB_DATA_W-1:0]        m_apb_prdata_i,
    input  logic                         m_apb_pready_i,
    input  logic                         m_apb_pslverr_i
);

    localparam int IDX_W = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE   = ARB_IDLE;
    localparam logic [1:0] S_SETUP  = ARB_SETUP;
    localparam logic [1:0] S_ACCESS = ARB_ACCESS;
    localparam logic [1:0] S_RESP   = ARB_RESP;

    logic [1:0]            state;
    logic [IDX_W-1:0]      grant_idx_q;
    logic [IDX_W-1:0]      last_grant;
    logic                  write_q;
    logic [APB_ADDR_W-1:0] addr_q;
    logic [APB_DATA_W-1:0] wdata_q;
    logic [APB_STRB_W-1:0] strb_q;
    logic [7:0]            wait_cnt;
    logic [APB_DATA_W-1:0] rdata_q;
    logic                  err_q;

    logic [NUM_REQ-1:0]    rr_grant;
    logic [IDX_W-1:0]      rr_idx;

    can_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .req        (req_valid_i),
        .last_grant (last_grant),
        .grant      (rr_grant),
        .grant_idx  (rr_idx)
    );

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state       <= S_IDLE;
            grant_idx_q <= '0;
            last_grant  <= IDX_W'(NUM_REQ - 1);
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            strb_q      <= '0;
            wait_cnt    <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        grant_idx_q <= rr_idx;
                        write_q     <= req_write_i[rr_idx];
                        addr_q      <= req_addr_i[int'(rr_idx)*APB_ADDR_W +: APB_ADDR_W];
                        wdata_q     <= req_wdata_i[int'(rr_idx)*APB_DATA_W +: APB_DATA_W];
                        strb_q      <= req_strb_i[int'(rr_idx)*APB_STRB_W +: APB_STRB_W];
                        state       <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    wait_cnt <= '0;
                    state    <= S_ACCESS;
                end
                S_ACCESS: begin
                    if (m_apb_pready_i) begin
                        rdata_q <= m_apb_prdata_i;
                        err_q   <= m_apb_pslverr_i;
                        state   <= S_RESP;
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        // ACCESS has lasted TIMEOUT cycles: abandon the slave
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    last_grant <= grant_idx_q;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

    // Accept is visible combinationally in IDLE; masking with arst keeps it quiet during reset
    assign req_ready_o     = (state == S_IDLE && !arst) ? rr_grant : '0;
    assign rsp_valid_o     = (state == S_RESP) ? (NUM_REQ'(1) << grant_idx_q) : '0;
    assign rsp_rdata_o     = (state == S_RESP) ? rdata_q : '0;
    assign rsp_err_o       = (state == S_RESP) && err_q;

    assign m_apb_psel_o    = (state == S_SETUP) || (state == S_ACCESS);
    assign m_apb_penable_o = (state == S_ACCESS);
    assign m_apb_pwrite_o  = m_apb_psel_o && write_q;
    assign m_apb_paddr_o   = m_apb_psel_o ? addr_q : '0;
    assign m_apb_pwdata_o  = m_apb_psel_o ? wdata_q : '0;
    assign m_apb_pstrb_o   = (m_apb_psel_o && write_q) ? strb_q : '0;
    assign m_apb_pprot_o   = APB_PROT_DEFAULT;

endmodule
